// File: rtl/led_axi_lite_slave_if.sv
// AXI4-Lite bus bundle for the LED register block.
// Handshake rule on every channel: a transfer happens on the rising edge where
// the producer's valid and the consumer's ready are both high; once valid is
// raised, the payload stays stable until that edge.
interface led_axi_lite_slave_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/led_axi_lite_slave.sv
// AXI4-Lite slave with four 32-bit registers driving an LED bus.
// reg0 = LED pattern, reg1[0] = blink enable, reg2 = blink half-period, reg3 = scratch.
// AW and W are captured independently; the write commits once both are held.
module led_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int LED_WIDTH          = 8
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  led_axi_lite_slave_if.slave  s_axi,
  output logic [LED_WIDTH-1:0] led
);
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

  logic                          aw_held;
  logic                          w_held;
  logic [1:0]                    aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]             w_strb_q;
  logic                          bvalid_q;
  logic                          rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic                          commit;

  logic [31:0] cnt;
  logic        ph;
  logic        blink_on;
  logic [31:0] last_cnt;

  // Protection bits and sub-word / upper address bits play no part in decode.
  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr, s_axi.araddr};

  assign s_axi.awready = !aw_held && !bvalid_q;
  assign s_axi.wready  = !w_held && !bvalid_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = !rvalid_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;

  // A write commits only when both halves are held and no response is pending.
  assign commit = aw_held && w_held && !bvalid_q;

  // Write channel capture, commit and response handshake.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx   <= 2'd0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid_q <= 1'b0;
    end else begin
      if (bvalid_q && s_axi.bready) begin
        bvalid_q <= 1'b0;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
      end else begin
        if (s_axi.awvalid && s_axi.awready) begin
          aw_held <= 1'b1;
          aw_idx  <= s_axi.awaddr[3:2];
        end
        if (s_axi.wvalid && s_axi.wready) begin
          w_held   <= 1'b1;
          w_data_q <= s_axi.wdata;
          w_strb_q <= s_axi.wstrb;
        end
      end
    end
  end

  // Register file: byte-lane update on commit, unstrobed lanes keep their value.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb_q[b]) begin
          regs[aw_idx][8*b +: 8] <= w_data_q[8*b +: 8];
        end
      end
    end
  end

  // Read channel: capture the pre-edge register value, hold it until accepted.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (s_axi.arvalid && s_axi.arready) begin
      rvalid_q <= 1'b1;
      rdata_q  <= regs[s_axi.araddr[3:2]];
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign blink_on = regs[1][0] && (regs[2] != 32'd0);
  assign last_cnt = regs[2] - 32'd1;

  // Blink generator: phase toggles every reg2 cycles; a shrunk period restarts
  // the count instead of letting it run up through 2^32.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt <= 32'd0;
      ph  <= 1'b1;
    end else if (!blink_on) begin
      cnt <= 32'd0;
      ph  <= 1'b1;
    end else if (cnt == last_cnt) begin
      cnt <= 32'd0;
      ph  <= ~ph;
    end else if (cnt > last_cnt) begin
      cnt <= 32'd0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

  // LED output register: pattern gated by the blink phase.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      led <= '0;
    end else begin
      led <= regs[0][LED_WIDTH-1:0] & {LED_WIDTH{ph}};
    end
  end
endmodule
